// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: op/funct decode, datapath enables and ALU control.
// Optional macro BNE_EN adds bne (op 000101) sharing the branch state with inverted taken.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;
  ctrl_t  ctrl_cur;
  logic   taken;

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: alu_of = 3'b000;
      6'b100010: alu_of = 3'b001;
      6'b100100: alu_of = 3'b010;
      6'b100101: alu_of = 3'b011;
      6'b101010: alu_of = 3'b101;
      default:   alu_of = 3'b111;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s, input logic [5:0] o);
    next_of = S_FETCH;
    case (s)
      S_FETCH:   next_of = S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: next_of = S_MEMADR;
          OP_RTYPE:     next_of = S_RTYPEEX;
          OP_BEQ:       next_of = S_BEQEX;
`ifdef BNE_EN
          OP_BNE:       next_of = S_BEQEX;
`endif
          OP_ADDI:      next_of = S_ADDIEX;
          OP_J:         next_of = S_JEX;
          default:      next_of = S_FETCH;
        endcase
      end
      S_MEMADR:  next_of = (o == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_of = S_MEMWB;
      S_RTYPEEX: next_of = S_RTYPEWB;
      S_ADDIEX:  next_of = S_ADDIWB;
      default:   next_of = S_FETCH;
    endcase
  endfunction

  // Moore control word for a state; unused and illegal codes leave everything 0.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f);
    ctrl_of = '0;
    case (s)
      S_FETCH: begin
        ctrl_of.alusrcb = 2'b01;
        ctrl_of.irwrite = 1'b1;
        ctrl_of.pcwrite = 1'b1;
      end
      S_DECODE:  ctrl_of.alusrcb = 2'b11;
      S_MEMADR: begin
        ctrl_of.alusrca = 1'b1;
        ctrl_of.alusrcb = 2'b10;
      end
      S_MEMRD:   ctrl_of.iord = 1'b1;
      S_MEMWB: begin
        ctrl_of.memtoreg = 1'b1;
        ctrl_of.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_of.iord     = 1'b1;
        ctrl_of.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_of.alusrca    = 1'b1;
        ctrl_of.alucontrol = alu_of(f);
      end
      S_RTYPEWB: begin
        ctrl_of.regdst   = 1'b1;
        ctrl_of.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl_of.alusrca    = 1'b1;
        ctrl_of.alucontrol = 3'b001;
        ctrl_of.pcsrc      = 2'b01;
        ctrl_of.branch     = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_of.alusrca = 1'b1;
        ctrl_of.alusrcb = 2'b10;
      end
      S_ADDIWB:  ctrl_of.regwrite = 1'b1;
      S_JEX: begin
        ctrl_of.pcsrc   = 2'b10;
        ctrl_of.pcwrite = 1'b1;
      end
      default:   ctrl_of = '0;
    endcase
  endfunction

  always_comb begin
    state_next = next_of(state_reg, op);
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      ctrl_reg  <= ctrl_of(S_FETCH, funct);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_of(state_next, funct);
    end
  end

  // During reset, selects show FETCH values while every write enable is held low.
  always_comb begin
    ctrl_cur = ctrl_reg;
    if (reset) begin
      ctrl_cur          = ctrl_of(S_FETCH, funct);
      ctrl_cur.pcwrite  = 1'b0;
      ctrl_cur.irwrite  = 1'b0;
      ctrl_cur.branch   = 1'b0;
      ctrl_cur.memwrite = 1'b0;
      ctrl_cur.regwrite = 1'b0;
    end
  end

`ifdef BNE_EN
  assign taken = (op == OP_BNE) ? ~zero : zero;
`else
  assign taken = zero;
`endif

  assign pcen       = ctrl_cur.pcwrite | (ctrl_cur.branch & taken);
  assign memwrite   = ctrl_cur.memwrite;
  assign irwrite    = ctrl_cur.irwrite;
  assign regwrite   = ctrl_cur.regwrite;
  assign iord       = ctrl_cur.iord;
  assign memtoreg   = ctrl_cur.memtoreg;
  assign regdst     = ctrl_cur.regdst;
  assign alusrca    = ctrl_cur.alusrca;
  assign alusrcb    = ctrl_cur.alusrcb;
  assign pcsrc      = ctrl_cur.pcsrc;
  assign alucontrol = ctrl_cur.alucontrol;
  assign state      = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction stream against an instruction-level model of the multicycle controller.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

`ifdef BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  // instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 illegal, 7 bne
  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int eff_class(input int cls);
    return (cls == 7 && !BNE_ON) ? 6 : cls;
  endfunction

  function automatic int instr_len(input int cls);
    case (eff_class(cls))
      0: return 5;
      1, 2, 4: return 4;
      3, 5, 7: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input int cls, input int c);
    if (c < 2) return 4'(c);
    case (eff_class(cls))
      0: return 4'(c);
      1: return (c == 2) ? 4'd2 : 4'd5;
      2: return 4'(c + 4);
      4: return 4'(c + 7);
      5: return 4'd11;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'd32: return 3'd0;
      6'd34: return 3'd1;
      6'd36: return 3'd2;
      6'd37: return 3'd3;
      6'd42: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] exp_ctrl(input int cls, input int c, input logic z,
                                           input logic [5:0] f);
    logic pe, mw, iw, rw, io, mr, rd, sa;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    int k;
    {pe, mw, iw, rw, io, mr, rd, sa, sb, ps, ac} = '0;
    k = eff_class(cls);
    if (c == 0) begin
      pe = 1; iw = 1; sb = 2'b01;
    end else if (c == 1) begin
      sb = 2'b11;
    end else begin
      case (k)
        0: if (c == 2) begin sa = 1; sb = 2'b10; end
           else if (c == 3) io = 1;
           else begin mr = 1; rw = 1; end
        1: if (c == 2) begin sa = 1; sb = 2'b10; end
           else begin io = 1; mw = 1; end
        2: if (c == 2) begin sa = 1; ac = alu_ref(f); end
           else begin rd = 1; rw = 1; end
        3, 7: begin sa = 1; ac = 3'b001; ps = 2'b01; pe = (k == 3) ? z : ~z; end
        4: if (c == 2) begin sa = 1; sb = 2'b10; end
           else rw = 1;
        5: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
    end
    return {pe, mw, iw, rw, io, mr, rd, sa, sb, ps, ac};
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] op_of(input int cls);
    logic [5:0] o;
    case (cls)
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      7: return 6'b000101;
      default: begin
        o = 6'($urandom);
        while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                         6'b000010, 6'b000101})
          o = 6'($urandom);
        return o;
      end
    endcase
  endfunction

  // Runs one instruction from FETCH; abort_c stops after checking that cycle.
  task automatic run_instr(input int cls, input logic [5:0] f, input int abort_c);
    int len;
    len = instr_len(cls);
    op = op_of(cls);
    funct = f;
    for (int c = 0; c < len; c++) begin
      zero = 1'($urandom);
      #1;
      chk("state", 15'(state), 15'(exp_state(cls, c)));
      chk("ctrl", obs_ctrl(), exp_ctrl(cls, c, zero, f));
      if (c == abort_c) return;
      @(posedge clk); #1;
    end
    $display("instr cls=%0d op=%b funct=%b cycles=%0d", cls, op, f, len);
  endtask

  logic [5:0] fsel [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};

  initial begin
    logic [5:0] f;
    int cls;
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b1;
    #1;
    chk("reset_async_view", obs_ctrl(), 15'b0_0_0_0_0_0_0_0_01_00_000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", 15'(state), 15'd0);
    chk("reset_ctrl", obs_ctrl(), 15'b0_0_0_0_0_0_0_0_01_00_000);
    reset = 1'b0;

    for (int n = 0; n < 60; n++) begin
      cls = (n < 8) ? n : int'($urandom_range(0, 7));
      f = fsel[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) f = 6'($urandom);
      run_instr(cls, f, -1);
    end

    // lw aborted by reset in MEMRD: no register write may follow
    run_instr(0, 6'd0, 3);
    reset = 1'b1; zero = 1'b1;
    #1;
    chk("abort_during_reset", obs_ctrl(), 15'b0_0_0_0_0_0_0_0_01_00_000);
    @(posedge clk); #1;
    chk("abort_state", 15'(state), 15'd0);
    chk("abort_regwrite", 15'(regwrite), 15'd0);
    reset = 1'b0;
    run_instr(1, 6'd0, -1);
    run_instr(2, 6'd42, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
